// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES key-expansion slice:
//   - key_len encodings (128/192/256/illegal)
//   - Nk / Nr lookup functions
//   - key-schedule FSM state enum
//   - RCON_INIT and the GF(2^8) xtime helper
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        KEY_LEN_128 = 2'b00,
        KEY_LEN_192 = 2'b01,
        KEY_LEN_256 = 2'b10,
        KEY_LEN_ILL = 2'b11
    } key_len_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN,
        ST_READY
    } state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Key length in 32-bit words. The illegal encoding maps to 4 so the
    // result is always a sane value; callers reject it separately.
    function automatic logic [3:0] nk_of(input logic [1:0] len);
        logic [3:0] nk;
        case (len)
            KEY_LEN_192: nk = 4'd6;
            KEY_LEN_256: nk = 4'd8;
            default:     nk = 4'd4;
        endcase
        return nk;
    endfunction

    // Number of rounds for the given key length.
    function automatic logic [3:0] nr_of(input logic [1:0] len);
        logic [3:0] nr;
        case (len)
            KEY_LEN_192: nr = 4'd12;
            KEY_LEN_256: nr = 4'd14;
            default:     nr = 4'd10;
        endcase
        return nr;
    endfunction

    // Multiply by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// ---------------------------------------------------------------------------
// aes_subword
// Applies the AES S-box to each byte of a 32-bit word (purely combinational).
// Ports:
//   word_in  [31:0]  input word
//   word_out [31:0]  byte-wise S-box substitution of word_in
// ---------------------------------------------------------------------------
module aes_subword (
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    // Entry 0 is the most significant byte of the packed constant.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    always_comb begin
        word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                    sbox(word_in[15:8]),  sbox(word_in[7:0])};
    end

endmodule

// File: rtl/aes_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_key_schedule
// Iterative AES-128/192/256 key expansion, one 32-bit schedule word per
// cycle into an internal round-key store, with a combinational 128-bit
// round-key read port.
//
// Optional feature macro: KEYEXP_ZEROIZE_EN (adds the zeroize port; store is
// wiped by zeroize and by reset). Without it the store survives reset.
//
// Parameters:
//   MAX_NK    largest supported key length in words (4, 6 or 8)
// Ports:
//   clk       clock
//   reset_n   synchronous active-low reset
//   zeroize   (KEYEXP_ZEROIZE_EN only) wipe store, force IDLE
//   start     request a new expansion
//   key_len   00=128, 01=192, 10=256, 11=illegal
//   key_in    cipher key, MSB-aligned
//   busy      expansion in progress
//   done      one-cycle pulse on schedule completion
//   ready     store holds a complete schedule
//   err       one-cycle pulse when start is rejected
//   rk_idx    round-key index to read
//   rk_out    round key rk_idx (word 4*rk_idx in [127:96]), 0 when invalid
//   rk_valid  ready and rk_idx <= Nr
// ---------------------------------------------------------------------------
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int unsigned MAX_NK = 8
) (
    input  logic         clk,
    input  logic         reset_n,
`ifdef KEYEXP_ZEROIZE_EN
    input  logic         zeroize,
`endif
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         ready,
    output logic         err,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         rk_valid
);

    localparam int unsigned DEPTH = 4 * (MAX_NK + 7);

    logic [31:0] store [DEPTH];

    state_e      state_q, state_d;
    logic [5:0]  i_q, i_d;       // index of the word being generated
    logic [3:0]  j_q, j_d;       // i mod Nk, tracked incrementally
    logic [7:0]  rcon_q, rcon_d;
    logic [3:0]  nk_q, nk_d;
    logic [3:0]  nr_q, nr_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept;         // start accepted this cycle: load key words
    logic        gen_we;         // write generated word w[i]
    logic        wipe;           // clear whole store
    logic        zero_req;
    logic        legal;

    logic [31:0] w_prev, w_back, sub_in, sub_out, temp, w_new;
    logic [5:0]  rk_base;

`ifdef KEYEXP_ZEROIZE_EN
    assign zero_req = zeroize;
    assign wipe     = !reset_n || zeroize;
`else
    assign zero_req = 1'b0;
    assign wipe     = 1'b0;
`endif

    assign legal = (key_len != KEY_LEN_ILL) && (32'(nk_of(key_len)) <= MAX_NK);

    // Word generation datapath; one S-box bank serves both the
    // RotWord+SubWord path (i mod Nk == 0) and the AES-256 mid-key SubWord.
    assign w_prev = store[i_q - 6'd1];
    assign w_back = store[i_q - {2'b00, nk_q}];
    assign sub_in = (j_q == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_subword u_subword (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    always_comb begin
        temp = w_prev;
        if (j_q == 4'd0)
            temp = sub_out ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && j_q == 4'd4)
            temp = sub_out;
        w_new = w_back ^ temp;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            rcon_q  <= '0;
            nk_q    <= '0;
            nr_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            rcon_q  <= rcon_d;
            nk_q    <= nk_d;
            nr_q    <= nr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        rcon_d  = rcon_q;
        nk_d    = nk_q;
        nr_d    = nr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        accept  = 1'b0;
        gen_we  = 1'b0;

        case (state_q)
            ST_IDLE, ST_READY: begin
                if (start) begin
                    if (legal) begin
                        accept  = 1'b1;
                        nk_d    = nk_of(key_len);
                        nr_d    = nr_of(key_len);
                        i_d     = {2'b00, nk_of(key_len)};
                        j_d     = '0;
                        rcon_d  = RCON_INIT;
                        state_d = ST_GEN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_GEN: begin
                gen_we = 1'b1;
                i_d    = i_q + 6'd1;
                j_d    = (j_q == nk_q - 4'd1) ? 4'd0 : j_q + 4'd1;
                if (j_q == 4'd0)
                    rcon_d = xtime(rcon_q);
                // Last word index W-1 = 4*Nr+3
                if (i_q == {nr_q, 2'b11}) begin
                    state_d = ST_READY;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (zero_req) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b0;
            accept  = 1'b0;
            gen_we  = 1'b0;
        end
    end

    // Round-key store; no reset unless zeroization is built in.
    always_ff @(posedge clk) begin
        if (wipe) begin
            for (int unsigned k = 0; k < DEPTH; k++)
                store[k] <= '0;
        end else if (reset_n && accept) begin
            for (int unsigned k = 0; k < MAX_NK; k++)
                if (k < 32'(nk_d))
                    store[k] <= key_in[255 - 32*k -: 32];
        end else if (reset_n && gen_we) begin
            store[i_q] <= w_new;
        end
    end

    // Outputs
    assign rk_base = {rk_idx, 2'b00};

    always_comb begin
        busy     = (state_q == ST_GEN);
        ready    = (state_q == ST_READY);
        done     = done_q;
        err      = err_q;
        rk_valid = (state_q == ST_READY) && (rk_idx <= nr_q);
        rk_out   = '0;
        if (rk_valid)
            rk_out = {store[rk_base], store[rk_base + 6'd1],
                      store[rk_base + 6'd2], store[rk_base + 6'd3]};
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_aes_key_schedule
// Directed-vector bench for aes_key_schedule using FIPS-197 key schedules.
// A second instance with MAX_NK=4 covers the key-length capability check.
// Build with KEYEXP_ZEROIZE_EN to include the zeroize scenario.
// ---------------------------------------------------------------------------
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start, start4;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic [3:0]   rk_idx;
`ifdef KEYEXP_ZEROIZE_EN
    logic         zeroize;
`endif

    logic         busy, done, ready, err, rk_valid;
    logic [127:0] rk_out;
    logic         busy4, done4, ready4, err4, rk_valid4;
    logic [127:0] rk_out4;

    int unsigned  errors = 0;
    int unsigned  checks = 0;

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always #5 clk = ~clk;

    aes_key_schedule #(.MAX_NK(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
`ifdef KEYEXP_ZEROIZE_EN
        .zeroize  (zeroize),
`endif
        .start    (start),
        .key_len  (key_len),
        .key_in   (key_in),
        .busy     (busy),
        .done     (done),
        .ready    (ready),
        .err      (err),
        .rk_idx   (rk_idx),
        .rk_out   (rk_out),
        .rk_valid (rk_valid)
    );

    aes_key_schedule #(.MAX_NK(4)) dut4 (
        .clk      (clk),
        .reset_n  (reset_n),
`ifdef KEYEXP_ZEROIZE_EN
        .zeroize  (1'b0),
`endif
        .start    (start4),
        .key_len  (key_len),
        .key_in   (key_in),
        .busy     (busy4),
        .done     (done4),
        .ready    (ready4),
        .err      (err4),
        .rk_idx   (rk_idx),
        .rk_out   (rk_out4),
        .rk_valid (rk_valid4)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a start for one edge; returns 1ns after the accepting edge.
    task automatic start_run(input string tag, input logic [1:0] len, input logic [255:0] key);
        @(negedge clk);
        key_len = len;
        key_in  = key;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_on"}, busy, 1);
        check({tag, "_ready_drop"}, ready, 0);
        check({tag, "_rkv_drop"}, rk_valid, 0);
    endtask

    // Wait for done (bounded), optionally poking start mid-GEN.
    task automatic wait_done(input string tag, input int exp_lat, input bit poke);
        int n = 0;
        bit seen = 0;
        bit gap = 0;
        while (n < 200 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1;
            else if (!busy) gap = 1;
            if (poke && n == 5) begin
                start   = 1'b1;
                key_len = 2'b00;
                key_in  = '1;
            end
            if (poke && n == 6) begin
                start = 1'b0;
                check({tag, "_gen_start_err"}, err, 0);
            end
        end
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_busy_gap"}, gap, 0);
        check({tag, "_busy_end"}, busy, 0);
        @(posedge clk);
        #1;
        check({tag, "_done_fall"}, done, 0);
        check({tag, "_ready"}, ready, 1);
    endtask

    task automatic rd(input string tag, input logic [3:0] idx, input logic [127:0] exp);
        rk_idx = idx;
        #1;
        check(tag, rk_out, exp);
    endtask

    task automatic run128(input string tag);
        start_run(tag, 2'b00, {K128, 128'h0});
        wait_done(tag, 40, 1'b0);
        rd({tag, "_rk0"}, 4'd0, K128);
        rd({tag, "_rk1"}, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
        rd({tag, "_rk10"}, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check({tag, "_rkv10"}, rk_valid, 1);
    endtask

    initial begin
        int dn;
        reset_n = 1'b0;
        start   = 1'b0;
        start4  = 1'b0;
        key_len = 2'b00;
        key_in  = '0;
        rk_idx  = 4'd0;
`ifdef KEYEXP_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", ready, 0);
        check("rst_err", err, 0);
        check("rst_rkv", rk_valid, 0);
        check("rst_rkout", rk_out, 0);
        reset_n = 1'b1;

        // AES-128 and out-of-range read
        run128("a128");
        rk_idx = 4'd11;
        #1;
        check("a128_rkv11", rk_valid, 0);
        check("a128_rkout11", rk_out, 0);

        // Illegal key_len from READY
        @(negedge clk);
        key_len = 2'b11;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ill_err", err, 1);
        check("ill_ready", ready, 1);
        check("ill_busy", busy, 0);
        @(posedge clk);
        #1;
        check("ill_err_fall", err, 0);
        rd("ill_rk10_kept", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-192 restart from READY, with a start poked during GEN
        start_run("a192", 2'b01, {K192, 64'h0});
        wait_done("a192", 46, 1'b1);
        rd("a192_rk12", 4'd12, 128'he98ba06f448c773c8ecc720401002202);

        // AES-256
        start_run("a256", 2'b10, K256);
        wait_done("a256", 52, 1'b0);
        rd("a256_rk14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
        rk_idx = 4'd15;
        #1;
        check("a256_rkv15", rk_valid, 0);

        // Reset mid-GEN
        start_run("mid", 2'b00, {K128, 128'h0});
        repeat (20) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_busy", busy, 0);
        check("mid_ready", ready, 0);
        dn = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 2) reset_n = 1'b1;
            if (done) dn++;
            @(posedge clk);
            #1;
        end
        check("mid_no_done", dn, 0);
        check("mid_idle_ready", ready, 0);
        run128("post");

        // MAX_NK=4 rejects a 256-bit key
        @(negedge clk);
        key_len = 2'b10;
        start4  = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        check("nk4_err", err4, 1);
        check("nk4_busy", busy4, 0);
        check("nk4_ready", ready4, 0);
        @(posedge clk);
        #1;
        check("nk4_err_fall", err4, 0);

`ifdef KEYEXP_ZEROIZE_EN
        @(negedge clk);
        zeroize = 1'b1;
        @(posedge clk);
        #1;
        zeroize = 1'b0;
        check("zero_ready", ready, 0);
        check("zero_rkout", rk_out, 0);
        start_run("z128", 2'b00, 256'h0);
        wait_done("z128", 40, 1'b0);
        rd("z128_rk0", 4'd0, 128'h0);
        rd("z128_rk1", 4'd1, 128'h62636363626363636263636362636363);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
